// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the pattern-detector's w input over a valid/ready handshake.
// Optional even-parity trailer bit is enabled by defining SERIAL_PARITY_EN.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sh_r, sh_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             w_r, w_s;
  logic             busy_r, busy_s;
  logic             ready_s;
  logic             accept_s;

`ifdef SERIAL_PARITY_EN
  logic par_r, par_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Acceptance window: idle, or the final cycle of the current frame.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:  ready_s = 1'b1;
`ifdef SERIAL_PARITY_EN
      SHIFT: ready_s = 1'b0;
      PAR:   ready_s = 1'b1;
`else
      SHIFT: ready_s = (cnt_r == LAST_CNT);
`endif
      default: ready_s = 1'b0;
    endcase
    in_ready = rst & ready_s;
    accept_s = in_valid & in_ready;
  end

  // Next-state, shifter, counter and next serial bit.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    cnt_s   = cnt_r;
    w_s     = w_r;
`ifdef SERIAL_PARITY_EN
    par_s   = par_r;
`endif
    if (accept_s) begin
      // The first bit goes straight to w; the shifter holds the remaining ones.
      state_s = SHIFT;
      cnt_s   = {CW{1'b0}};
`ifdef SERIAL_PARITY_EN
      par_s   = even_parity(in_data);
`endif
      if (MSB_FIRST) begin
        w_s  = in_data[WIDTH-1];
        sh_s = {in_data[WIDTH-2:0], 1'b0};
      end else begin
        w_s  = in_data[0];
        sh_s = {1'b0, in_data[WIDTH-1:1]};
      end
    end else begin
      case (state_r)
        IDLE: begin
          w_s = IDLE_BIT;
        end
        SHIFT: begin
          if (cnt_r != LAST_CNT) begin
            cnt_s = cnt_r + CW'(1'b1);
            if (MSB_FIRST) begin
              w_s  = sh_r[WIDTH-1];
              sh_s = {sh_r[WIDTH-2:0], 1'b0};
            end else begin
              w_s  = sh_r[0];
              sh_s = {1'b0, sh_r[WIDTH-1:1]};
            end
          end else begin
`ifdef SERIAL_PARITY_EN
            state_s = PAR;
            w_s     = par_r;
`else
            state_s = IDLE;
            w_s     = IDLE_BIT;
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        PAR: begin
          state_s = IDLE;
          w_s     = IDLE_BIT;
        end
`endif
        default: begin
          state_s = IDLE;
          w_s     = IDLE_BIT;
          cnt_s   = {CW{1'b0}};
          sh_s    = {WIDTH{1'b0}};
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      sh_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      w_r     <= IDLE_BIT;
      busy_r  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
      w_r     <= w_s;
      busy_r  <= busy_s;
`ifdef SERIAL_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign w       = w_r;
  assign busy    = busy_r;
  assign w_valid = busy_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: an MSB-first and an LSB-first
// instance share stimulus; parity expectations follow SERIAL_PARITY_EN.
module tb_bit_serializer;

`ifdef SERIAL_PARITY_EN
  localparam int FR = 9;
`else
  localparam int FR = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready_m, w_m, w_valid_m, busy_m;
  logic       in_ready_l, w_l, w_valid_l, busy_l;

  int n_total;
  int n_bad;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .w(w_m), .w_valid(w_valid_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .w(w_l), .w_valid(w_valid_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ready);
    check_val({tag, "/w_m"},    32'(w_m),        32'd0);
    check_val({tag, "/wv_m"},   32'(w_valid_m),  32'd0);
    check_val({tag, "/busy_m"}, 32'(busy_m),     32'd0);
    check_val({tag, "/rdy_m"},  32'(in_ready_m), 32'(exp_ready));
    check_val({tag, "/w_l"},    32'(w_l),        32'd0);
    check_val({tag, "/busy_l"}, 32'(busy_l),     32'd0);
  endtask

  // em/el: expected stream, first bit in [8]; [0] is the parity bit when enabled.
  task automatic send_one(input string tag, input logic [7:0] d,
                          input logic [8:0] em, input logic [8:0] el);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    check_val({tag, "/rdy_pre"}, 32'(in_ready_m), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < FR; k++) begin
      if (k > 0) @(negedge clk);
      check_val($sformatf("%s/w_m[%0d]", tag, k),  32'(w_m),        32'(em[8-k]));
      check_val($sformatf("%s/w_l[%0d]", tag, k),  32'(w_l),        32'(el[8-k]));
      check_val($sformatf("%s/wv_m[%0d]", tag, k), 32'(w_valid_m),  32'd1);
      check_val($sformatf("%s/rdy[%0d]", tag, k),  32'(in_ready_m), 32'(k == FR - 1));
    end
    @(negedge clk);
    check_idle({tag, "/after"}, 1'b1);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0);
    rst = 1'b1;

    // Idle level for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle[%0d]", i), 1'b1);
    end

    // Single word B2, both bit orders
    send_one("b2", 8'hB2, 9'b1_0110_0100, 9'b0_1001_1010);

    // Back-to-back FF then 00 with in_valid held
    @(negedge clk);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = 8'h00;
    for (int i = 0; i < 2 * FR; i++) begin
      if (i > 0) @(negedge clk);
      if (i == FR) in_valid = 1'b0;
      check_val($sformatf("b2b/w_m[%0d]", i),  32'(w_m),        32'(i < 8));
      check_val($sformatf("b2b/w_l[%0d]", i),  32'(w_l),        32'(i < 8));
      check_val($sformatf("b2b/wv[%0d]", i),   32'(w_valid_m),  32'd1);
      check_val($sformatf("b2b/rdy[%0d]", i),  32'(in_ready_m), 32'((i == FR - 1) || (i == 2 * FR - 1)));
    end
    @(negedge clk);
    check_idle("b2b/after", 1'b1);

    // Reset mid-frame after the third bit of AA
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check_val($sformatf("rmid/w_m[%0d]", k), 32'(w_m), 32'(k % 2 == 0));
      check_val($sformatf("rmid/w_l[%0d]", k), 32'(w_l), 32'(k % 2 == 1));
    end
    rst = 1'b0;
    #1;
    check_idle("rmid/assert", 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_idle("rmid/held", 1'b0);
    end
    rst = 1'b1;
    #1;
    check_val("rmid/rdy_release", 32'(in_ready_m), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("rmid/post[%0d]", i), 1'b1);
    end

`ifdef SERIAL_PARITY_EN
    // Parity trailer: 07 has odd weight, 03 even
    send_one("p07", 8'h07, 9'b0_0000_1111, 9'b1_1100_0001);
    send_one("p03", 8'h03, 9'b0_0000_0110, 9'b1_1000_0000);
`else
    send_one("w07", 8'h07, 9'b0_0000_1110, 9'b1_1100_0000);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the serial pattern-detector FSM and drives its single-bit `w` input, one bit per clock. It accepts words over a valid/ready handshake and shifts them out in a fixed bit order. When no word is in flight, it drives a defined idle level so the downstream FSM always samples a known value. It supports back-to-back words with no gap cycles.

Parameters:
WIDTH, 8, bits per input word (legal range 2..32)
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first
IDLE_BIT, 0, level driven on `w` when no bit is being shifted

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_data  input  WIDTH  word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
w  output  1  serial bit stream to the downstream detector
w_valid  output  1  w carries a data (or parity) bit this cycle
busy  output  1  a frame is in progress

Behaviour:
- Reset is asynchronous and active-low on `rst`. While rst=0:
  - state=IDLE, shift register=0, bit counter=0.
  - w=IDLE_BIT, w_valid=0, busy=0.
  - in_ready is forced to 0.
- States:
  - IDLE: no frame in flight.
  - SHIFT: data bits being driven.
  - PAR: parity bit being driven; exists only with the optional feature.
- Accept: a word is taken at a rising edge where in_valid=1 and in_ready=1. in_data is sampled only at that edge. in_data and in_valid are don't-care otherwise.
- in_ready is combinational and equals 1 when rst=1 and either:
  - state is IDLE, or
  - the current cycle is the last cycle of the frame: SHIFT with cnt=WIDTH-1 and no parity, or PAR.
- Latency:
  - A word accepted at edge N drives its first bit on w after edge N.
  - Bit k appears in the cycle following edge N+k, for k=0..WIDTH-1.
  - w, w_valid and busy are all registered outputs.
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] first, down to bit 0.
  - MSB_FIRST=0: bit 0 first, up to bit WIDTH-1.
- Counter: cnt is $clog2(WIDTH) bits wide. It is loaded to 0 on accept and increments by 1 each SHIFT cycle. It never wraps inside a frame.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT stays in SHIFT while cnt<WIDTH-1.
  - On the last SHIFT cycle:
    - with a new accept: reload and stay in SHIFT. No gap; w_valid stays 1.
    - without an accept: go to IDLE, or to PAR if the feature is enabled.
  - PAR: on accept -> SHIFT; otherwise -> IDLE.
- busy = 1 exactly while state ≠ IDLE. w_valid = busy.
- In IDLE, w holds IDLE_BIT every cycle.
- Reset asserted mid-frame:
  - The frame is dropped immediately (asynchronously). No partial bits follow.
  - After rst deasserts, the block resumes in IDLE.
- If in_valid rises in the same cycle rst deasserts, the word is not accepted in that cycle, because in_ready was 0 before the edge.
- The illegal or unused state encoding recovers to IDLE on the next edge with w=IDLE_BIT.

Optional Feature:
- Macro: `SERIAL_PARITY_EN`.
- Defined:
  - After the WIDTH data bits, one PAR cycle drives the even-parity bit (XOR reduction of the accepted word) on w, with w_valid=1.
  - A frame is therefore WIDTH+1 cycles.
  - The back-to-back accept point moves from the last SHIFT cycle to the PAR cycle.
- Not defined:
  - The PAR state and parity logic are absent.
  - A frame is exactly WIDTH cycles.

Test Plan:
1. Single word, MSB-first: WIDTH=8, MSB_FIRST=1, after reset send 8'hB2 once.
   -> w = 1,0,1,1,0,0,1,0 over 8 consecutive cycles, w_valid=1 for exactly those 8 cycles, then w=0 and busy=0.
2. Single word, LSB-first: MSB_FIRST=0, send 8'hB2.
   -> w = 0,1,0,0,1,1,0,1.
3. Back-to-back: hold in_valid=1 with 8'hFF then 8'h00.
   -> in_ready pulses on the cycle after acceptance plus 7.
   -> w = eight 1s immediately followed by eight 0s, w_valid continuous for 16 cycles.
4. Idle level: IDLE_BIT=0, in_valid=0 for 20 cycles after reset.
   -> w=0, w_valid=0, in_ready=1 throughout.
5. Reset mid-frame: send 8'hAA, assert rst low after the 3rd bit, release 2 cycles later.
   -> w=IDLE_BIT and busy=0 immediately on assertion.
   -> no remaining bits of 8'hAA appear.
   -> in_ready=0 during reset and 1 after release.
6. Parity (with `SERIAL_PARITY_EN`): send 8'h07.
   -> 9 bits 0,0,0,0,0,1,1,1,1 (parity=1).
   -> then send 8'h03: parity bit=0.
